sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_pkg.sv | 23 ++
 rtl/rr_pick.sv | 20 ++
 rtl/sram_arbiter.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// ---------------------------------------------------------------------------
// sram_pkg -- shared definitions for the two-core SRAM arbiter.
//   arb_state_t    : arbiter FSM states (IDLE, GRANT0, GRANT1)
//   ADDR_W_DEFAULT : default word-address width of cores and memory port
//   COUNT_MAX      : saturation value of the per-core grant counters
//   sat_inc()      : saturating 32-bit increment
// ---------------------------------------------------------------------------
package sram_pkg;

    localparam int          ADDR_W_DEFAULT = 17;
    localparam logic [31:0] COUNT_MAX      = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] value);
        return (value == COUNT_MAX) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick -- two-input round-robin selector.
//   req0, req1 : request lines
//   prio       : favoured input when both request (0 = input 0)
//   valid      : at least one request present
//   sel        : index of the chosen input (meaningful only when valid)
// ---------------------------------------------------------------------------
module rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic prio,
    output logic valid,
    output logic sel
);

    assign valid = req0 | req1;
    // A lone request wins outright; a tie goes to the favoured input.
    assign sel   = (req0 & req1) ? prio : req1;

endmodule

// File: rtl/sram_arbiter.sv
// ---------------------------------------------------------------------------
// sram_arbiter -- shares one memory-controller CPU port between two cores.
//   clock, reset            : sole clock; synchronous active-high reset
//   coreN{Read,Write}Enable : core N request strobes (either one = request)
//   coreNAddress/WriteData  : core N access address and write data
//   coreNStall              : core N must hold its request this cycle
//   coreNReadData           : memory read data on completion, else last read
//   coreNDone               : core N finished (latched, sticky)
//   mem*                    : forwarded request of the granted core
//   memStall / memReadData  : memory controller busy flag / read data
//   memDoneFlag             : registered, both cores have signalled done
//   grantCount0/1           : saturating count of completed accesses
// A grant lasts until the access completes (enable high, memStall low) or
// the core withdraws; the FSM always passes through IDLE between grants.
// ---------------------------------------------------------------------------
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEFAULT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              core0ReadEnable,
    input  logic              core0WriteEnable,
    input  logic [ADDR_W-1:0] core0Address,
    input  logic [31:0]       core0WriteData,
    output logic              core0Stall,
    output logic [31:0]       core0ReadData,
    input  logic              core0Done,
    input  logic              core1ReadEnable,
    input  logic              core1WriteEnable,
    input  logic [ADDR_W-1:0] core1Address,
    input  logic [31:0]       core1WriteData,
    output logic              core1Stall,
    output logic [31:0]       core1ReadData,
    input  logic              core1Done,
    output logic              memReadEnable,
    output logic              memWriteEnable,
    output logic [ADDR_W-1:0] memAddress,
    output logic [31:0]       memWriteData,
    input  logic              memStall,
    input  logic [31:0]       memReadData,
    output logic              memDoneFlag,
    output logic [31:0]       grantCount0,
    output logic [31:0]       grantCount1
);

    arb_state_t  state, state_next;
    logic        prio;
    logic        req0, req1;
    logic        pick_valid, pick_sel;
    logic        complete0, complete1;
    logic [31:0] read_hold0, read_hold1;
    logic [31:0] count0, count1;
    logic        done0, done1;
    logic        done_both;

    assign req0 = core0ReadEnable | core0WriteEnable;
    assign req1 = core1ReadEnable | core1WriteEnable;

    rr_pick u_pick (
        .req0  (req0),
        .req1  (req1),
        .prio  (prio),
        .valid (pick_valid),
        .sel   (pick_sel)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next     = state;
        memReadEnable  = 1'b0;
        memWriteEnable = 1'b0;
        memAddress     = '0;
        memWriteData   = '0;
        complete0      = 1'b0;
        complete1      = 1'b0;

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = pick_sel ? GRANT1 : GRANT0;
                end
            end

            GRANT0: begin
                // Write wins when a core raises both strobes.
                memWriteEnable = core0WriteEnable;
                memReadEnable  = core0ReadEnable & ~core0WriteEnable;
                memAddress     = core0Address;
                memWriteData   = core0WriteData;
                if (req0 && !memStall) begin
                    complete0  = 1'b1;
                    state_next = IDLE;
                end else if (!req0) begin
                    state_next = IDLE;
                end
            end

            GRANT1: begin
                memWriteEnable = core1WriteEnable;
                memReadEnable  = core1ReadEnable & ~core1WriteEnable;
                memAddress     = core1Address;
                memWriteData   = core1WriteData;
                if (req1 && !memStall) begin
                    complete1  = 1'b1;
                    state_next = IDLE;
                end else if (!req1) begin
                    state_next = IDLE;
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // A requesting core is held off until the cycle its access completes.
    assign core0Stall    = req0 & ~complete0;
    assign core1Stall    = req1 & ~complete1;
    assign core0ReadData = complete0 ? memReadData : read_hold0;
    assign core1ReadData = complete1 ? memReadData : read_hold1;

    // The done flags feed memDoneFlag through their next values so the
    // combined flag rises on the same edge as the second sticky flag.
    assign done_both = (done0 | core0Done) & (done1 | core1Done);

    always_ff @(posedge clock) begin
        if (reset) begin
            prio        <= 1'b0;
            count0      <= '0;
            count1      <= '0;
            read_hold0  <= '0;
            read_hold1  <= '0;
            done0       <= 1'b0;
            done1       <= 1'b0;
            memDoneFlag <= 1'b0;
        end else begin
            done0       <= done0 | core0Done;
            done1       <= done1 | core1Done;
            memDoneFlag <= done_both;
            if (complete0) begin
                prio   <= 1'b1;
                count0 <= sat_inc(count0);
                if (!core0WriteEnable) begin
                    read_hold0 <= memReadData;
                end
            end
            if (complete1) begin
                prio   <= 1'b0;
                count1 <= sat_inc(count1);
                if (!core1WriteEnable) begin
                    read_hold1 <= memReadData;
                end
            end
        end
    end

    assign grantCount0 = count0;
    assign grantCount1 = count1;

endmodule
